difficulty_scheduler: RTL

Owns game pacing for the runner datapath. On each game tick it compares the LFSR sample against a decaying threshold and decides whether the surface generator takes a transition. It tightens the tick-timer period and the surface transition spacing as the game progresses. It sits between the game FSM, the LFSR, the tick timer and the surface generator, and replaces the ad-hoc pacing arithmetic in the game FSM.

---
 rtl/difficulty_pkg.sv | 22 ++
 rtl/difficulty_scheduler_rng_threshold.sv | 39 +++
 rtl/difficulty_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/difficulty_pkg.sv
// Shared types and default pacing constants for the difficulty scheduler slice.
package difficulty_pkg;

    localparam int PERIOD_W = 10;
    localparam int DIFF_W   = 4;
    localparam int RNG_W    = 16;

    localparam logic [PERIOD_W-1:0] DEF_PERIOD_INIT  = 10'd150;
    localparam logic [PERIOD_W-1:0] DEF_PERIOD_FLOOR = 10'd100;
    localparam logic [PERIOD_W-1:0] DEF_PERIOD_FINAL = 10'd90;
    localparam logic [DIFF_W-1:0]   DEF_DIFF_INIT    = 4'd4;
    localparam logic [DIFF_W-1:0]   DEF_DIFF_MIN     = 4'd1;
    localparam logic [RNG_W-1:0]    DEF_THRESH_INIT  = 16'h80FF;
    localparam logic [RNG_W-1:0]    DEF_THRESH_STEP  = 16'd50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        MAXED = 2'd2
    } state_e;

endpackage

// File: rtl/difficulty_scheduler_rng_threshold.sv
// Decaying RNG threshold: reload on transition/start, saturating step-down on a miss.
// hit is combinational from the current threshold; the update lands one cycle later.
module rng_threshold
    import difficulty_pkg::*;
#(
    parameter logic [RNG_W-1:0] THRESH_INIT = DEF_THRESH_INIT,
    parameter logic [RNG_W-1:0] THRESH_STEP = DEF_THRESH_STEP
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             reload,
    input  logic             dec,
    input  logic [RNG_W-1:0] rng_q,
    output logic             hit
);

    logic [RNG_W-1:0] thresh_q, thresh_d;

    always_comb begin
        thresh_d = thresh_q;
        if (reload) begin
            thresh_d = THRESH_INIT;
        end else if (dec) begin
            // Clamp at zero so a long dry spell cannot wrap to a near-impossible threshold.
            thresh_d = (thresh_q > THRESH_STEP) ? (thresh_q - THRESH_STEP) : '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            thresh_q <= THRESH_INIT;
        end else begin
            thresh_q <= thresh_d;
        end
    end

    assign hit = (rng_q > thresh_q);

endmodule

// File: rtl/difficulty_scheduler.sv
// Game pacing: decides surface transitions per tick and tightens tick period / spacing.
// All outputs registered, one cycle after GameTick or Start; Pause holds all state.
module difficulty_scheduler
    import difficulty_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] PERIOD_INIT  = DEF_PERIOD_INIT,
    parameter logic [PERIOD_W-1:0] PERIOD_FLOOR = DEF_PERIOD_FLOOR,
    parameter logic [PERIOD_W-1:0] PERIOD_FINAL = DEF_PERIOD_FINAL,
    parameter logic [DIFF_W-1:0]   DIFF_INIT    = DEF_DIFF_INIT,
    parameter logic [DIFF_W-1:0]   DIFF_MIN     = DEF_DIFF_MIN,
    parameter logic [RNG_W-1:0]    THRESH_INIT  = DEF_THRESH_INIT,
    parameter logic [RNG_W-1:0]    THRESH_STEP  = DEF_THRESH_STEP
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic                Run,
    input  logic                Pause,
    input  logic                GameTick,
    input  logic [RNG_W-1:0]    RngQ,
    output logic                TransTick,
    output logic [PERIOD_W-1:0] TickPeriod,
    output logic [DIFF_W-1:0]   TransDiff,
    output logic [3:0]          Level,
    output logic                Maxed,
    output logic                CfgUpd
);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DIFF_W-1:0]   diff_q, diff_d;
    logic [3:0]          level_q, level_d;
    logic                maxed_q, maxed_d;
    logic                trans_q, trans_d;
    logic                cfg_q, cfg_d;
    logic                tick_ok;
    logic                hit;

    // Start and a falling Run both pre-empt a tick in the same cycle.
    assign tick_ok = GameTick && !Pause && Run && !Start && (state_q != IDLE);

    rng_threshold #(
        .THRESH_INIT (THRESH_INIT),
        .THRESH_STEP (THRESH_STEP)
    ) u_thresh (
        .Clk    (Clk),
        .Rst    (Rst),
        .reload (Start || (tick_ok && hit)),
        .dec    (tick_ok && !hit),
        .rng_q  (RngQ),
        .hit    (hit)
    );

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        diff_d   = diff_q;
        level_d  = level_q;
        maxed_d  = maxed_q;
        trans_d  = 1'b0;
        cfg_d    = 1'b0;

        if (Start) begin
            period_d = PERIOD_INIT;
            diff_d   = DIFF_INIT;
            level_d  = 4'd0;
            maxed_d  = 1'b0;
            state_d  = Run ? RUN : IDLE;
        end else if (state_q != IDLE && !Run) begin
            state_d = IDLE;
        end else if (tick_ok && hit) begin
            trans_d = 1'b1;
            if (state_q == RUN) begin
                if (period_q > PERIOD_FLOOR) begin
                    period_d = period_q - 1'b1;
                end else if (diff_q > DIFF_MIN) begin
                    diff_d   = diff_q - 1'b1;
                    period_d = PERIOD_INIT;
                    level_d  = (level_q == 4'hF) ? level_q : level_q + 1'b1;
                end else begin
                    period_d = PERIOD_FINAL;
                    level_d  = (level_q == 4'hF) ? level_q : level_q + 1'b1;
                    maxed_d  = 1'b1;
                    state_d  = MAXED;
                end
            end
        end

        cfg_d = Start || (period_d != period_q) || (diff_d != diff_q);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= IDLE;
            period_q <= PERIOD_INIT;
            diff_q   <= DIFF_INIT;
            level_q  <= 4'd0;
            maxed_q  <= 1'b0;
            trans_q  <= 1'b0;
            cfg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            diff_q   <= diff_d;
            level_q  <= level_d;
            maxed_q  <= maxed_d;
            trans_q  <= trans_d;
            cfg_q    <= cfg_d;
        end
    end

    assign TransTick  = trans_q;
    assign TickPeriod = period_q;
    assign TransDiff  = diff_q;
    assign Level      = level_q;
    assign Maxed      = maxed_q;
    assign CfgUpd     = cfg_q;

endmodule
